// File: rtl/time_set_ctrl.sv
// time_set_ctrl: UART command front-end for the clock's time counter chain.
//   "S" HH MM SS CR  -> validate, pulse set_en with the new time, reply 'K' (or 'E').
//   "R"              -> snapshot current time, send "HHMMSS\r\n".
// A set command that stalls between bytes for TIMEOUT_CYCLES is abandoned silently.
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TO_W           = 26
) (
    input  logic       clk,
    input  logic       resett,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       set_en,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       busy
);

    // FSM encoding
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_DIG = 3'd1;
    localparam logic [2:0] GET_CR  = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] APPLY   = 3'd4;
    localparam logic [2:0] TX_ACK  = 3'd5;
    localparam logic [2:0] TX_TIME = 3'd6;

    // Protocol characters
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Last counter value before a stalled set command is abandoned
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state_r;
    logic [2:0]      dig_idx_r;   // digits received so far in GET_DIG
    logic [23:0]     dig_r;       // shift register of BCD digits, H1 ends up in [23:20]
    logic [TO_W-1:0] to_cnt_r;
    logic [4:0]      snap_hour_r;
    logic [5:0]      snap_min_r;
    logic [5:0]      snap_sec_r;
    logic [2:0]      tx_idx_r;    // which of the 8 time bytes is current

    logic [6:0]      hour_s;
    logic [6:0]      min_s;
    logic [6:0]      sec_s;
    logic            time_ok_s;
    logic [7:0]      tx_byte_s;

    // ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Two BCD digits to binary (0..99)
    function automatic logic [6:0] two_digit(input logic [3:0] hi, input logic [3:0] lo);
        return ({3'b000, hi} * 7'd10) + {3'b000, lo};
    endfunction

    // Tens digit of a value 0..63 without a divider
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd60) begin
            t = 4'd6;
        end else if (v >= 6'd50) begin
            t = 4'd5;
        end else if (v >= 6'd40) begin
            t = 4'd4;
        end else if (v >= 6'd30) begin
            t = 4'd3;
        end else if (v >= 6'd20) begin
            t = 4'd2;
        end else if (v >= 6'd10) begin
            t = 4'd1;
        end else begin
            t = 4'd0;
        end
        return t;
    endfunction

    // ASCII of the tens digit
    function automatic logic [7:0] ascii_tens(input logic [5:0] v);
        return {4'h3, tens_of(v)};
    endfunction

    // ASCII of the ones digit
    function automatic logic [7:0] ascii_ones(input logic [5:0] v);
        logic [5:0] o;
        o = v - ({2'b00, tens_of(v)} * 6'd10);
        return {4'h3, o[3:0]};
    endfunction

    assign busy = (state_r != IDLE);

    // Range check of the received digits and selection of the next time byte to send
    always_comb begin
        hour_s    = two_digit(dig_r[23:20], dig_r[19:16]);
        min_s     = two_digit(dig_r[15:12], dig_r[11:8]);
        sec_s     = two_digit(dig_r[7:4],   dig_r[3:0]);
        time_ok_s = (hour_s <= 7'd23) && (min_s <= 7'd59) && (sec_s <= 7'd59);
        tx_byte_s = 8'h00;
        case (tx_idx_r)
            3'd0:    tx_byte_s = ascii_tens({1'b0, snap_hour_r});
            3'd1:    tx_byte_s = ascii_ones({1'b0, snap_hour_r});
            3'd2:    tx_byte_s = ascii_tens(snap_min_r);
            3'd3:    tx_byte_s = ascii_ones(snap_min_r);
            3'd4:    tx_byte_s = ascii_tens(snap_sec_r);
            3'd5:    tx_byte_s = ascii_ones(snap_sec_r);
            3'd6:    tx_byte_s = CH_CR;
            3'd7:    tx_byte_s = CH_LF;
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Command FSM, timeout counter, load outputs and TX byte presentation
    always_ff @(posedge clk) begin
        if (resett) begin
            state_r     <= IDLE;
            dig_idx_r   <= 3'd0;
            dig_r       <= 24'd0;
            to_cnt_r    <= '0;
            snap_hour_r <= 5'd0;
            snap_min_r  <= 6'd0;
            snap_sec_r  <= 6'd0;
            tx_idx_r    <= 3'd0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            set_en      <= 1'b0;
            set_hour    <= 5'd0;
            set_min     <= 6'd0;
            set_sec     <= 6'd0;
        end else begin
            // set_en is a single-cycle strobe; only CHECK raises it
            set_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_valid && (rx_data == CH_S)) begin
                        dig_idx_r <= 3'd0;
                        to_cnt_r  <= '0;
                        state_r   <= GET_DIG;
                    end else if (rx_valid && (rx_data == CH_R)) begin
                        // Snapshot this cycle's time so later ticks cannot tear the reply
                        snap_hour_r <= cur_hour;
                        snap_min_r  <= cur_min;
                        snap_sec_r  <= cur_sec;
                        tx_idx_r    <= 3'd0;
                        state_r     <= TX_TIME;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GET_DIG: begin
                    // A byte arriving on the expiry cycle still wins over the timeout
                    if (rx_valid) begin
                        to_cnt_r <= '0;
                        if (is_digit(rx_data)) begin
                            dig_r <= {dig_r[19:0], rx_data[3:0]};
                            if (dig_idx_r == 3'd5) begin
                                state_r <= GET_CR;
                            end else begin
                                dig_idx_r <= dig_idx_r + 3'd1;
                            end
                        end else begin
                            tx_data  <= CH_E;
                            tx_valid <= 1'b1;
                            state_r  <= TX_ACK;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        to_cnt_r <= '0;
                        state_r  <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                GET_CR: begin
                    if (rx_valid) begin
                        to_cnt_r <= '0;
                        if (rx_data == CH_CR) begin
                            state_r <= CHECK;
                        end else begin
                            tx_data  <= CH_E;
                            tx_valid <= 1'b1;
                            state_r  <= TX_ACK;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        to_cnt_r <= '0;
                        state_r  <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                CHECK: begin
                    // Load is registered on the way into APPLY so set_en is high during APPLY
                    if (time_ok_s) begin
                        set_hour <= hour_s[4:0];
                        set_min  <= min_s[5:0];
                        set_sec  <= sec_s[5:0];
                        set_en   <= 1'b1;
                        state_r  <= APPLY;
                    end else begin
                        tx_data  <= CH_E;
                        tx_valid <= 1'b1;
                        state_r  <= TX_ACK;
                    end
                end
                APPLY: begin
                    tx_data  <= CH_K;
                    tx_valid <= 1'b1;
                    state_r  <= TX_ACK;
                end
                TX_ACK: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        tx_valid <= 1'b1;
                    end
                end
                TX_TIME: begin
                    // Present a byte, hold it until accepted, then leave one idle cycle
                    if (!tx_valid) begin
                        tx_data  <= tx_byte_s;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (tx_idx_r == 3'd7) begin
                            state_r <= IDLE;
                        end else begin
                            tx_idx_r <= tx_idx_r + 3'd1;
                        end
                    end else begin
                        tx_valid <= 1'b1;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
